// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch front end and its environment: the control
// decoder handshake, the ALU-supplied targets/addresses and the memory port.
interface fetch_unit_if;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic [31:0] data_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] mdr;
    logic [31:0] pc;
    logic        fetch_timeout;

    // The fetch unit side.
    modport master (
        input  pc_write, pc_src, branch_taken, branch_target, reg_target,
               data_addr, mem_rdata, mem_ready,
        output mem_rd, mem_addr, ins, ins_valid, mdr, pc, fetch_timeout
    );

    // Control decoder, ALU and memory side.
    modport slave (
        output pc_write, pc_src, branch_taken, branch_target, reg_target,
               data_addr, mem_rdata, mem_ready,
        input  mem_rd, mem_addr, ins, ins_valid, mdr, pc, fetch_timeout
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, IR and MDR plus the fetch / data-access
// sequencer with variable memory latency and a sticky wait timeout.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_FETCH | first cycle of an instruction fetch at pc
//  S_WAIT  | fetch issued, memory not ready yet; counting wait cycles
//  S_EXEC  | IR valid, control decoder drives pc_write/pc_src this cycle
//  S_DATA  | lw/sw data round at data_addr; counting wait cycles
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          MAX_WAIT = 15
) (
    input  logic  clock,
    input  logic  reset_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_DATA} state_t;

    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [31:0] PC_STEP_C  = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] pc_plus;
    logic [31:0] next_pc;
    logic [7:0]  wait_inc;

    assign pc_plus  = pc_q + PC_STEP_C;
    assign wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // PC selection for the instruction completing in EXEC.
    always_comb begin
        next_pc = pc_plus;
        unique case (bus.pc_src)
            2'b00: next_pc = pc_plus;
            2'b01: next_pc = {pc_plus[31:28], ir_q[25:0], 2'b00};
            2'b10: next_pc = bus.branch_taken ? bus.branch_target : pc_plus;
            2'b11: next_pc = bus.reg_target;
        endcase
    end

    // Sequencer next-state: fetch with wait counting, exec handshake, data round.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    state_d = S_EXEC;
                end else begin
                    wait_cnt_d = 8'd1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT, S_DATA: begin
                if (bus.mem_ready) begin
                    if (state_q == S_WAIT) ir_d  = bus.mem_rdata;
                    else                   mdr_d = bus.mem_rdata;
                    wait_cnt_d = 8'd0;
                    state_d    = S_EXEC;
                end else begin
                    wait_cnt_d = wait_inc;
                    // Keep waiting after a timeout; the flag only reports it.
                    if (wait_cnt_q == MAX_WAIT_C) timeout_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (bus.pc_write) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DATA;
                end
            end
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            mdr_q      <= 32'h0;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.mem_rd        = (state_q != S_EXEC);
    assign bus.mem_addr      = (state_q == S_DATA) ? bus.data_addr : pc_q;
    assign bus.ins_valid     = (state_q == S_EXEC);
    assign bus.ins           = ir_q;
    assign bus.mdr           = mdr_q;
    assign bus.pc            = pc_q;
    assign bus.fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a round-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a fetch round (any number of misses), one exec cycle,
    // or a data round (any number of misses).
    localparam int P_FETCH = 0, P_EXEC = 1, P_DATA = 2;
    int          m_phase;
    int          m_miss;
    logic [31:0] m_pc, m_ir, m_mdr;
    logic        m_to;
    bit          model_on = 0;

    always @(posedge clock) begin
        logic [31:0] seq;
        if (!reset_n) begin
            m_phase = P_FETCH; m_miss = 0; m_pc = 32'h0; m_ir = 32'h0;
            m_mdr = 32'h0; m_to = 1'b0; model_on = 1;
        end else if (model_on) begin
            seq = m_pc + 32'd4;
            if (m_phase == P_EXEC) begin
                if (bus.pc_write) begin
                    case (bus.pc_src)
                        2'd0: m_pc = seq;
                        2'd1: m_pc = (seq & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
                        2'd2: m_pc = bus.branch_taken ? bus.branch_target : seq;
                        default: m_pc = bus.reg_target;
                    endcase
                    m_phase = P_FETCH;
                end else begin
                    m_phase = P_DATA;
                end
                m_miss = 0;
            end else if (bus.mem_ready) begin
                if (m_phase == P_FETCH) m_ir = bus.mem_rdata;
                else                    m_mdr = bus.mem_rdata;
                m_phase = P_EXEC;
                m_miss  = 0;
            end else begin
                m_miss++;
                if (m_miss > MAX_WAIT) m_to = 1'b1;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (model_on) begin
            chk("mem_rd",    32'(bus.mem_rd),    32'(m_phase != P_EXEC));
            chk("mem_addr",  bus.mem_addr,       (m_phase == P_DATA) ? bus.data_addr : m_pc);
            chk("ins_valid", 32'(bus.ins_valid), 32'(m_phase == P_EXEC));
            chk("ins",       bus.ins,            m_ir);
            chk("mdr",       bus.mdr,            m_mdr);
            chk("pc",        bus.pc,             m_pc);
            chk("timeout",   32'(bus.fetch_timeout), 32'(m_to));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic rdy, input logic [31:0] rd);
        bus.mem_ready = rdy;
        bus.mem_rdata = rd;
        tick();
    endtask

    // Zero-wait fetch, then complete in EXEC with the given pc_src.
    task automatic do_instr(input logic [31:0] w, input logic [1:0] src);
        bus.pc_write = 1'b1;       // ignored outside EXEC
        bus.pc_src   = ~src;
        step(1'b1, w);
        bus.pc_src   = src;
        step(1'b0, 32'hBAD0_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc_write = 0; bus.pc_src = 0; bus.branch_taken = 0;
        bus.branch_target = 0; bus.reg_target = 0; bus.data_addr = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;

        // Reset with a pending mem_ready
        bus.mem_ready = 1; bus.mem_rdata = 32'h1111_1111;
        tick(); tick();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ins", bus.ins, 32'h0);
        chk("rst_valid", 32'(bus.ins_valid), 32'h0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'h1);
        chk("rst_timeout", 32'(bus.fetch_timeout), 32'h0);
        reset_n = 1;

        // 1: zero-wait sequential instructions
        bus.pc_write = 1; bus.pc_src = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", bus.mem_addr, 32'(4 * i));
            chk("t1_valid_lo", 32'(bus.ins_valid), 32'h0);
            step(1'b1, 32'h2000_0000 + 32'(i));
            chk("t1_valid_hi", 32'(bus.ins_valid), 32'h1);
            chk("t1_ins", bus.ins, 32'h2000_0000 + 32'(i));
            step(1'b0, 32'h0);
        end
        chk("t1_pc", bus.pc, 32'd12);

        // 2: memory ready after 3 wait cycles
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_rd", 32'(bus.mem_rd), 32'h1);
            step(1'b0, 32'hCAFE_0000 + 32'(i));
        end
        chk("t2_mem_rd4", 32'(bus.mem_rd), 32'h1);
        chk("t2_ins_hold", bus.ins, 32'h2000_0002);
        step(1'b1, 32'h2400_0042);
        chk("t2_valid", 32'(bus.ins_valid), 32'h1);
        chk("t2_ins", bus.ins, 32'h2400_0042);
        chk("t2_timeout", 32'(bus.fetch_timeout), 32'h0);
        step(1'b0, 32'h0);
        chk("t2_pc", bus.pc, 32'd16);

        // 3: lw data round
        bus.pc_write = 0;
        step(1'b1, 32'h8C00_0000);
        bus.data_addr = 32'h100;
        step(1'b0, 32'h0);
        chk("t3_daddr", bus.mem_addr, 32'h100);
        chk("t3_drd", 32'(bus.mem_rd), 32'h1);
        step(1'b0, 32'h5151_5151);
        step(1'b1, 32'hDEAD_BEEF);
        chk("t3_mdr", bus.mdr, 32'hDEAD_BEEF);
        chk("t3_ins", bus.ins, 32'h8C00_0000);
        chk("t3_valid", 32'(bus.ins_valid), 32'h1);
        chk("t3_pc_hold", bus.pc, 32'd16);
        bus.pc_write = 1; bus.pc_src = 2'b00;
        step(1'b0, 32'h0);
        chk("t3_pc", bus.pc, 32'd20);

        // 4: branch / jump-register / jump
        bus.reg_target = 32'h40;       do_instr(32'h0, 2'b11);
        chk("t4_jr40", bus.pc, 32'h40);
        bus.branch_target = 32'h80; bus.branch_taken = 1; do_instr(32'h0, 2'b10);
        chk("t4_taken", bus.pc, 32'h80);
        bus.reg_target = 32'h40;       do_instr(32'h0, 2'b11);
        bus.branch_taken = 0;          do_instr(32'h0, 2'b10);
        chk("t4_not_taken", bus.pc, 32'h44);
        bus.reg_target = 32'h1234;     do_instr(32'h0, 2'b11);
        chk("t4_jr", bus.pc, 32'h1234);
        do_instr(32'h0000_0010, 2'b01);
        chk("t4_jump", bus.pc, 32'h40);
        bus.reg_target = 32'hA000_0000; do_instr(32'h0, 2'b11);
        do_instr(32'hFFFF_FFFF, 2'b01);
        chk("t4_jump_hi", bus.pc, 32'hAFFF_FFFC);

        // 5: fetch stalled 20 cycles
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 32'h0);
            chk("t5_timeout", 32'(bus.fetch_timeout), 32'(i >= 16));
        end
        step(1'b1, 32'h2800_0000);
        chk("t5_valid", 32'(bus.ins_valid), 32'h1);
        bus.pc_write = 1; bus.pc_src = 2'b00;
        step(1'b0, 32'h0);
        chk("t5_pc", bus.pc, 32'hB000_0000);
        chk("t5_sticky", 32'(bus.fetch_timeout), 32'h1);

        // 6: reset during DATA, then during WAIT, then PC wrap
        bus.pc_write = 0; bus.data_addr = 32'h200;
        step(1'b1, 32'h8C00_0001);
        step(1'b0, 32'h0);
        step(1'b1, 32'h5555_AAAA);
        chk("t6_mdr", bus.mdr, 32'h5555_AAAA);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        reset_n = 0;
        step(1'b1, 32'h1234_5678);
        chk("t6d_pc", bus.pc, 32'h0);
        chk("t6d_mdr", bus.mdr, 32'h0);
        chk("t6d_timeout", 32'(bus.fetch_timeout), 32'h0);
        chk("t6d_ins", bus.ins, 32'h0);
        chk("t6d_addr", bus.mem_addr, 32'h0);
        chk("t6d_valid", 32'(bus.ins_valid), 32'h0);
        reset_n = 1;
        bus.reg_target = 32'h300; do_instr(32'h0, 2'b11);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        reset_n = 0;
        step(1'b1, 32'h0000_0077);
        chk("t6w_pc", bus.pc, 32'h0);
        chk("t6w_ins", bus.ins, 32'h0);
        chk("t6w_valid", 32'(bus.ins_valid), 32'h0);
        reset_n = 1;
        bus.reg_target = 32'hFFFF_FFFC; do_instr(32'h0, 2'b11);
        chk("t6_pcmax", bus.pc, 32'hFFFF_FFFC);
        do_instr(32'h0, 2'b00);
        chk("t6_wrap", bus.pc, 32'h0);

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
